// File: rtl/block_collision_detector_if.sv
// Bus between the block manager / doodle physics and the collision detector:
// scan handshake, doodle position, the flattened platform grid and the result.
interface block_collision_detector_if #(
  parameter int N = 100
);
  logic            start;
  logic [31:0]     doodleX;
  logic [31:0]     doodleY;
  logic            falling;
  logic            newView;
  logic [32*N-1:0] blocksX_flat;
  logic [32*N-1:0] blocksY_flat;
  logic [N-1:0]    active_flat;
  logic            busy;
  logic            done;
  logic            aborted;
  logic            hasCollide;
  logic [31:0]     collisionX;
  logic [31:0]     collisionY;

  modport master (
    output start, doodleX, doodleY, falling, newView,
           blocksX_flat, blocksY_flat, active_flat,
    input  busy, done, aborted, hasCollide, collisionX, collisionY
  );

  modport slave (
    input  start, doodleX, doodleY, falling, newView,
           blocksX_flat, blocksY_flat, active_flat,
    output busy, done, aborted, hasCollide, collisionX, collisionY
  );
endinterface

// File: rtl/block_collision_detector.sv
// Sequential landing detector: walks the platform grid one block per clock and
// reports the lowest-index active block the falling doodle lands on.
module block_collision_detector #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BLOCK_WIDTH   = 64,
  parameter int BLOCK_HEIGHT  = 48,
  parameter int BLOCK_THICK   = 8,
  parameter int DOODLE_WIDTH  = 32
) (
  input logic clk,
  input logic reset,
  block_collision_detector_if.slave bus
);
  localparam int BW = SCREEN_WIDTH / BLOCK_WIDTH;
  localparam int BH = SCREEN_HEIGHT / BLOCK_HEIGHT;
  localparam int N  = BW * BH;
  localparam int KW = $clog2(N + 1);
  localparam int IW = $clog2(BW);
  localparam int JW = $clog2(BH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [31:0]   latX;
  logic [31:0]   latY;
  logic          latFalling;

  logic          fValid;
  logic          fActive;
  logic          fLast;
  logic [31:0]   fX;
  logic [31:0]   fY;
  logic [IW-1:0] fI;
  logic [JW-1:0] fJ;

  logic          busyR;
  logic          doneR;
  logic          abortedR;
  logic          hitR;
  logic [31:0]   colX;
  logic [31:0]   colY;

  logic          xHit;
  logic          yHit;
  logic          hit;

  // Compare against the block fetched last cycle, keeping the wide grid mux and
  // the comparators in separate cycles; sums are widened so nothing wraps.
  always_comb begin
    yHit = (fY <= latY) &&
           ({1'b0, latY} < ({1'b0, fY} + 33'(BLOCK_THICK)));
    xHit = (({1'b0, latX} + 33'(DOODLE_WIDTH)) > {1'b0, fX}) &&
           ({1'b0, latX} < ({1'b0, fX} + 33'(BLOCK_WIDTH)));
    hit  = fValid && fActive && latFalling && yHit && xHit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      k          <= '0;
      i          <= '0;
      j          <= '0;
      latX       <= '0;
      latY       <= '0;
      latFalling <= 1'b0;
      fValid     <= 1'b0;
      fActive    <= 1'b0;
      fLast      <= 1'b0;
      fX         <= '0;
      fY         <= '0;
      fI         <= '0;
      fJ         <= '0;
      busyR      <= 1'b0;
      doneR      <= 1'b0;
      abortedR   <= 1'b0;
      hitR       <= 1'b0;
      colX       <= '0;
      colY       <= '0;
    end else begin
      doneR    <= 1'b0;
      abortedR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.newView) begin
            latX       <= bus.doodleX;
            latY       <= bus.doodleY;
            latFalling <= bus.falling;
            k          <= '0;
            i          <= '0;
            j          <= '0;
            fValid     <= 1'b0;
            busyR      <= 1'b1;
            state      <= SCAN;
          end
        end
        SCAN: begin
          if (bus.newView) begin
            fValid   <= 1'b0;
            busyR    <= 1'b0;
            abortedR <= 1'b1;
            state    <= IDLE;
          end else if (fValid && (hit || fLast)) begin
            hitR   <= hit;
            if (hit) begin
              colX <= 32'(fI);
              colY <= 32'(fJ);
            end
            fValid <= 1'b0;
            busyR  <= 1'b0;
            doneR  <= 1'b1;
            state  <= DONE;
          end else begin
            // k never passes N-1 here: the block fetched at N-1 ends the scan next cycle.
            fValid  <= 1'b1;
            fActive <= bus.active_flat[k];
            fX      <= bus.blocksX_flat[{k, 5'b0} +: 32];
            fY      <= bus.blocksY_flat[{k, 5'b0} +: 32];
            fI      <= i;
            fJ      <= j;
            fLast   <= (k == KW'(N - 1));
            k       <= k + 1'b1;
            if (i == IW'(BW - 1)) begin
              i <= '0;
              j <= j + 1'b1;
            end else begin
              i <= i + 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busyR;
  assign bus.done       = doneR;
  assign bus.aborted    = abortedR;
  assign bus.hasCollide = hitR;
  assign bus.collisionX = colX;
  assign bus.collisionY = colY;
endmodule
